// File: rtl/instr_seq_pkg.sv
// Shared definitions for instr_fetch_sequencer and instructdecoder: opcodes, field positions, FSM states.
// Define SEQ_SINGLE_STEP_EN to add the PAUSE state used by single-step mode.
package instr_seq_pkg;

  localparam logic [3:0] OP_MOV  = 4'b1100;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_DEC  = 4'b0110;
  localparam logic [3:0] OP_HALT = 4'b1000;

  localparam int OPC_HI = 17;
  localparam int OPC_LO = 14;
  localparam int RD_HI  = 13;
  localparam int RD_LO  = 11;
  localparam int RS_HI  = 10;
  localparam int RS_LO  = 8;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_MEMWAIT,
    S_ISSUE,
    S_HALTED
`ifdef SEQ_SINGLE_STEP_EN
    ,
    S_PAUSE
`endif
  } seq_state_t;

endpackage

// File: rtl/instr_fetch_sequencer.sv
// Fetches instruction words from synchronous-read memory and hands them to the decoder over valid/ready.
// Optional single-step mode (step_mode/step ports, PAUSE state) when SEQ_SINGLE_STEP_EN is defined.
module instr_fetch_sequencer
  import instr_seq_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int IW     = 18,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic              step_mode,
  input  logic              step,
`endif
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd_en,
  input  logic [IW-1:0]     imem_rdata,
  output logic [IW-1:0]     id,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [15:0]       instr_count
);

  seq_state_t state, state_nxt;
  logic       is_halt;

  assign is_halt    = (id[OPC_HI:OPC_LO] == OP_HALT);
  assign imem_rd_en = (state == S_FETCH);
  assign imem_addr  = pc;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_FETCH;
      S_FETCH:   state_nxt = S_MEMWAIT;
      S_MEMWAIT: state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (id_ready) begin
          if (is_halt) state_nxt = S_HALTED;
`ifdef SEQ_SINGLE_STEP_EN
          else if (step_mode) state_nxt = S_PAUSE;
`endif
          else state_nxt = S_FETCH;
        end
      end
      S_HALTED:  if (start) state_nxt = S_FETCH;
`ifdef SEQ_SINGLE_STEP_EN
      S_PAUSE:   if (step) state_nxt = S_FETCH;
`endif
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers; memory data arriving after a reset is simply never captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      id          <= '0;
      id_valid    <= 1'b0;
      halted      <= 1'b0;
      instr_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pc_load) pc <= pc_load_val;
          if (start)   instr_count <= '0;
        end
        S_MEMWAIT: begin
          id       <= imem_rdata;
          id_valid <= 1'b1;
        end
        S_ISSUE: begin
          if (id_ready) begin
            id_valid <= 1'b0;
            if (instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
            if (is_halt) halted <= 1'b1;
            else         pc <= pc + 1'b1;
          end
        end
        S_HALTED: begin
          if (start) begin
            pc          <= pc_load ? pc_load_val : RESET_PC;
            halted      <= 1'b0;
            instr_count <= '0;
          end else if (pc_load) begin
            pc <= pc_load_val;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed bench for instr_fetch_sequencer with a behavioural instruction memory and fetch/issue scoreboards.
module tb_instr_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, pc_load, id_ready;
  logic [7:0]  pc_load_val, imem_addr, pc;
  logic        imem_rd_en, id_valid, halted;
  logic [17:0] imem_rdata, id;
  logic [15:0] instr_count;
`ifdef SEQ_SINGLE_STEP_EN
  logic        step_mode, step;
`endif

  instr_fetch_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .pc_load(pc_load), .pc_load_val(pc_load_val),
`ifdef SEQ_SINGLE_STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .imem_addr(imem_addr), .imem_rd_en(imem_rd_en), .imem_rdata(imem_rdata),
    .id(id), .id_valid(id_valid), .id_ready(id_ready), .pc(pc), .halted(halted),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  logic [17:0] mem [0:255];
  always @(posedge clk) if (imem_rd_en) imem_rdata <= mem[imem_addr];

  int checks = 0, failures = 0, valid_cycles = 0;
  logic [7:0]  exp_addr [$];
  logic [17:0] exp_id   [$];
  logic [17:0] prog [0:5];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every fetch and every handshake is matched against what the stimulus queued.
  task automatic monitor();
    if (!rst && imem_rd_en) begin
      if (exp_addr.size() == 0) chk("fetch_unexpected", 32'(exp_addr.size()), 32'd1);
      else chk("fetch_addr", 32'(imem_addr), 32'(exp_addr.pop_front()));
    end
    if (!rst && id_valid) valid_cycles++;
    if (!rst && id_valid && id_ready) begin
      if (exp_id.size() == 0) chk("issue_unexpected", 32'(exp_id.size()), 32'd1);
      else chk("issue_id", 32'(id), 32'(exp_id.pop_front()));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!id_valid && n < 40) begin tick(); n++; end
    chk(tag, 32'(id_valid), 32'd1);
  endtask

  task automatic wait_halted(input string tag);
    int n = 0;
    while (!halted && n < 80) begin tick(); n++; end
    chk(tag, 32'(halted), 32'd1);
  endtask

  task automatic queue_run(input int first, input int last);
    for (int a = first; a <= last; a++) begin
      exp_addr.push_back(8'(a));
      exp_id.push_back(prog[a]);
    end
  endtask

  initial begin
    int vc0;
    prog[0] = 18'b110010100011111000; // MOV R5,F8
    prog[1] = 18'b110011000011001100; // MOV R6,CC
    prog[2] = 18'b001110111000000000; // SUB R5,R6
    prog[3] = 18'b011010100000000000; // DEC R5
    prog[4] = 18'b011010100000000000; // DEC R5
    prog[5] = 18'b100010111011001100; // HALT
    for (int a = 0; a < 256; a++) mem[a] = 18'h0;
    for (int a = 0; a < 6; a++) mem[a] = prog[a];
    rst = 1'b1; start = 1'b0; pc_load = 1'b0; pc_load_val = 8'h00; id_ready = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    step_mode = 1'b0; step = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_id", 32'(id), 32'h0);
    chk("rst_id_valid", 32'(id_valid), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_count", 32'(instr_count), 32'h0);
    chk("rst_rd_en", 32'(imem_rd_en), 32'h0);

    // IDLE pc_load alone
    pc_load = 1'b1; pc_load_val = 8'h10; tick(); pc_load = 1'b0;
    chk("idle_load_pc", 32'(pc), 32'h10);
    chk("idle_no_fetch", 32'(imem_rd_en), 32'h0);

    // Straight run, pc_load with start in IDLE, id_ready held high
    queue_run(0, 5);
    id_ready = 1'b1; pc_load = 1'b1; pc_load_val = 8'h00; start = 1'b1;
    vc0 = valid_cycles;
    tick(); start = 1'b0; pc_load = 1'b0;
    chk("t1_fetch_en", 32'(imem_rd_en), 32'h1);
    chk("t1_fetch_pc", 32'(pc), 32'h0);
    wait_halted("t1_halted");
    chk("t1_pc", 32'(pc), 32'h5);
    chk("t1_count", 32'(instr_count), 32'd6);
    chk("t1_id_valid", 32'(id_valid), 32'h0);
    chk("t1_valid_cycles", 32'(valid_cycles - vc0), 32'd6);

    // Restart from HALTED at 3
    queue_run(3, 5);
    pc_load = 1'b1; pc_load_val = 8'h03; start = 1'b1;
    tick(); start = 1'b0; pc_load = 1'b0;
    chk("rs_halted_clr", 32'(halted), 32'h0);
    chk("rs_count_clr", 32'(instr_count), 32'h0);
    chk("rs_pc", 32'(pc), 32'h3);
    chk("rs_fetch_en", 32'(imem_rd_en), 32'h1);
    wait_halted("rs_halted");
    chk("rs_pc_end", 32'(pc), 32'h5);
    chk("rs_count_end", 32'(instr_count), 32'd3);

    // Manual handshakes with backpressure on word 2; restart without pc_load uses RESET_PC
    queue_run(0, 5);
    id_ready = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    chk("bp_pc_reset", 32'(pc), 32'h0);
    for (int i = 0; i < 6; i++) begin
      wait_valid("bp_valid");
      chk("bp_id", 32'(id), 32'(prog[i]));
      if (i == 2) begin
        repeat (4) begin
          tick();
          chk("bp_hold_id", 32'(id), 32'(prog[2]));
          chk("bp_hold_valid", 32'(id_valid), 32'h1);
          chk("bp_hold_rd_en", 32'(imem_rd_en), 32'h0);
          chk("bp_hold_pc", 32'(pc), 32'h2);
        end
      end
      id_ready = 1'b1; tick(); id_ready = 1'b0;
      if (i < 5) chk("bp_pc_adv", 32'(pc), 32'(i + 1));
      chk("bp_count", 32'(instr_count), 32'(i + 1));
    end
    chk("bp_halted", 32'(halted), 32'h1);
    chk("bp_pc_end", 32'(pc), 32'h5);

    // PC wrap: FE, FF, then HALT at 00
    mem[8'hFE] = prog[0]; mem[8'hFF] = prog[3]; mem[0] = prog[5];
    exp_addr.push_back(8'hFE); exp_addr.push_back(8'hFF); exp_addr.push_back(8'h00);
    exp_id.push_back(prog[0]); exp_id.push_back(prog[3]); exp_id.push_back(prog[5]);
    id_ready = 1'b1; pc_load = 1'b1; pc_load_val = 8'hFE; start = 1'b1;
    tick(); start = 1'b0; pc_load = 1'b0;
    chk("wr_pc_start", 32'(pc), 32'hFE);
    wait_halted("wr_halted");
    chk("wr_pc_end", 32'(pc), 32'h0);
    chk("wr_count", 32'(instr_count), 32'd3);
    mem[0] = prog[0];

    // Reset while in MEMWAIT
    exp_addr.push_back(8'h00);
    id_ready = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    chk("mr_fetch_en", 32'(imem_rd_en), 32'h1);
    tick();
    chk("mr_memwait_rd_en", 32'(imem_rd_en), 32'h0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mr_id_valid", 32'(id_valid), 32'h0);
    chk("mr_id", 32'(id), 32'h0);
    chk("mr_pc", 32'(pc), 32'h0);
    chk("mr_halted", 32'(halted), 32'h0);
    chk("mr_count", 32'(instr_count), 32'h0);
    tick();
    chk("mr_idle_rd_en", 32'(imem_rd_en), 32'h0);
    chk("mr_idle_valid", 32'(id_valid), 32'h0);
    queue_run(0, 5);
    id_ready = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    wait_halted("mr_rerun_halted");
    chk("mr_rerun_count", 32'(instr_count), 32'd6);
    chk("mr_rerun_pc", 32'(pc), 32'h5);

`ifdef SEQ_SINGLE_STEP_EN
    queue_run(0, 5);
    step_mode = 1'b1; id_ready = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_valid("ss_valid");
      tick();
      repeat (3) begin
        chk("ss_pause_rd_en", 32'(imem_rd_en), 32'h0);
        chk("ss_pause_valid", 32'(id_valid), 32'h0);
        tick();
      end
      step = 1'b1; tick(); step = 1'b0;
      chk("ss_step_fetch", 32'(imem_rd_en), 32'h1);
    end
    wait_halted("ss_halted");
    chk("ss_pc_end", 32'(pc), 32'h5);
    step_mode = 1'b0;
`endif

    chk("addr_q_drained", 32'(exp_addr.size()), 32'd0);
    chk("id_q_drained", 32'(exp_id.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
